load_store_unit: RTL
====================

# load_store_unit

CPU-side load/store unit. It sits directly upstream of the memory system and drives the `memory_bus` CONSUMER side. It accepts one RISC-V load/store request at a time from the core and sequences the single-cycle dispatch/busy handshake. It returns width-masked, sign- or zero-extended load data, with misalignment checks and a watchdog timeout.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 256: maximum cycles spent in WAIT before the request is aborted with an error; 8-bit counter, legal range 8..255 plus 256 (encoded as 0).

Ports:
- `clk_in`  in  1  system clock
- `rst_in`  in  1  reset; asynchronous, active-high
- `req_valid`  in  1  core presents a request
- `req_ready`  out  1  unit can accept; `(state==IDLE) && !bus.busy`
- `req_is_store`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RISC-V funct3: LB/SB=0, LH/SH=1, LW/SW=2, LBU=4, LHU=5
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data; low bytes are significant
- `resp_valid`  out  1  one-cycle response pulse
- `resp_data`  out  32  extended load data; 0 for stores and errors
- `resp_error`  out  1  misaligned or timed-out; qualified by `resp_valid`
- `bus`  `memory_bus.CONSUMER`: `addr`, `write_data`, `dispatch_read`, `dispatch_write`, `mem_width` out; `read_data`, `busy` in

## Operation
States:
- **IDLE**
  - On `req_valid && req_ready`, latch the request into `addr_q`, `wdata_q`, `f3_q` and `store_q`.
  - If the request is misaligned (see Configuration), go to RESP with error set.
  - Otherwise go to DISPATCH.
- **DISPATCH**
  - Assert exactly one of `dispatch_read` / `dispatch_write` for exactly one cycle.
  - `addr` = `addr_q`; `write_data` = `wdata_q`.
  - `mem_width` = BYTE for f3[1:0]=0, WORD for 1, DWORD for 2.
  - Clear the timeout counter, then go to WAIT.
- **WAIT**
  - Sample `bus.busy` every cycle.
  - On the first cycle with `busy==0`, capture `bus.read_data` and go to RESP.
  - Otherwise increment the counter. If the counter reaches `TIMEOUT_CYCLES`, go to RESP with error set.
- **RESP**
  - Pulse `resp_valid` for one cycle and return to IDLE.

Load extension:
- f3=0: `{{24{rd[7]}}, rd[7:0]}`
- f3=4: `{24'b0, rd[7:0]}`
- f3=1: `{{16{rd[15]}}, rd[15:0]}`
- f3=5: `{16'b0, rd[15:0]}`
- f3=2: `rd`

Other rules:
- Illegal funct3 values (3, 6, 7) are treated as errors at acceptance and never dispatched.
- While not in DISPATCH, `bus.addr` and `bus.write_data` hold their last values and both dispatch lines are 0.
- After a timeout, `req_ready` stays low until the memory drops `busy`. No new dispatch is issued into a busy memory.

## Timing
- Reset values: `req_ready`=0 while `rst_in` is high; `resp_valid`=0, `resp_data`=0, `resp_error`=0, both dispatch lines 0, `bus.addr`=0, `bus.write_data`=0, `mem_width`=BYTE; state = IDLE.
- Reset asserted mid-request forces IDLE immediately and drops any dispatch pulse. The in-flight memory access is abandoned.
- Accept at cycle T; dispatch high at T+1; WAIT from T+2.
- `resp_valid` rises one cycle after the WAIT cycle that sees `busy==0`.
- Minimum latency (IO read, 1-cycle memory): `resp_valid` at T+4.
- Error on misalignment or illegal funct3: `resp_valid` at T+1, with no bus activity.
- Timeout: `resp_valid` at T+2+`TIMEOUT_CYCLES`.
- All outputs are registered, except `req_ready`, which is combinational on state and `bus.busy`.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Defined:
  - halfword with `addr[0]`=1 is an error;
  - word with `addr[1:0]`≠0 is an error;
  - errors produce a `resp_valid` + `resp_error` pulse with no dispatch.
- Undefined:
  - the alignment check is removed;
  - the address is forwarded unchanged, relying on the byte-serial RAM path;
  - only illegal funct3 values and timeout raise `resp_error`.

## Structure
- `mem` package additions:
  - `lsu_funct3_t` enum (LB=0, LH=1, LW=2, LBU=4, LHU=5);
  - `lsu_state_t` enum (IDLE, DISPATCH, WAIT, RESP);
  - function `funct3_to_width` returning `mem_width_t`.
- One sub-module: `lsu_load_extend`, combinational; inputs `rd[31:0]` and `f3`, output extended data.

## Test plan
- LB at 0x10004, memory returns 0x000000F0 → `resp_data`=0xFFFFFFF0, `resp_error`=0; dispatch_read high exactly 1 cycle with `mem_width`=BYTE.
- LHU at 0x10002, returns 0x0000BEEF → `resp_data`=0x0000BEEF. LH with the same return → 0xFFFFBEEF.
- SW 0xDEADBEEF to 0x20010 → dispatch_write with `write_data`=0xDEADBEEF, `mem_width`=DWORD; `resp_valid` with `resp_data`=0 after `busy` falls.
- With `LSU_MISALIGN_TRAP_EN`, LW at 0x10001 → `resp_error`=1 at T+1 and no dispatch. Without the macro → dispatch at address 0x10001.
- `busy` held high for 300 cycles, `TIMEOUT_CYCLES`=256 → `resp_error` at T+258; `req_ready` stays 0 until `busy` drops.
- `rst_in` asserted during WAIT → all outputs return to reset values in the same cycle; the next request dispatches normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: memory access widths, RISC-V load
// funct3 codes, LSU states and the funct3 decode helpers.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    WORD  = 2'd1,
    DWORD = 2'd2
  } mem_width_t;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } lsu_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    WAIT,
    RESP
  } lsu_state_t;

  function automatic mem_width_t funct3_to_width(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return BYTE;
      2'd1:    return WORD;
      default: return DWORD;
    endcase
  endfunction

  // 3, 6 and 7 have no load/store meaning
  function automatic logic funct3_legal(input logic [2:0] f3);
    return (f3[1:0] != 2'b11) && (f3 != 3'd6);
  endfunction

endpackage

// File: rtl/memory_bus.sv
// Single-transaction memory bus: one-cycle dispatch strobe, then the memory
// holds busy until read_data is valid.
interface memory_bus;
  import load_store_unit_pkg::*;

  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        dispatch_read;
  logic        dispatch_write;
  logic        busy;
  mem_width_t  mem_width;

  modport CONSUMER (
    output addr, write_data, dispatch_read, dispatch_write, mem_width,
    input  read_data, busy
  );

  modport PROVIDER (
    input  addr, write_data, dispatch_read, dispatch_write, mem_width,
    output read_data, busy
  );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Width-masks raw memory read data and sign- or zero-extends it according to
// the load funct3.
module lsu_load_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rd,
  input  logic [2:0]  f3,
  output logic [31:0] data
);

  always_comb begin
    case (f3)
      LB:      data = {{24{rd[7]}}, rd[7:0]};
      LBU:     data = {24'b0, rd[7:0]};
      LH:      data = {{16{rd[15]}}, rd[15:0]};
      LHU:     data = {16'b0, rd[15:0]};
      default: data = rd;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time and sequences it onto
// memory_bus. Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
//
// state    | meaning
// IDLE     | ready for a request when memory is not busy
// DISPATCH | one-cycle read/write strobe on the bus
// WAIT     | waiting for busy to drop, watchdog running
// RESP     | resp_valid pulse, then back to IDLE
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_error,
  memory_bus.CONSUMER bus
);

  // 256 wraps to 0 so the 8-bit down-counter still hits terminal count at 1
  localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT_CYCLES);

  lsu_state_t  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic        store_q;
  logic [7:0]  tmo_cnt;
  logic        dispatch_read_q;
  logic        dispatch_write_q;
  mem_width_t  width_q;
  logic        accept;
  logic        req_err;
  logic [31:0] load_data;

  assign req_ready = !rst_in && (state == IDLE) && !bus.busy;
  assign accept    = req_valid && req_ready;

  assign bus.addr           = addr_q;
  assign bus.write_data     = wdata_q;
  assign bus.dispatch_read  = dispatch_read_q;
  assign bus.dispatch_write = dispatch_write_q;
  assign bus.mem_width      = width_q;

  always_comb begin
    req_err = !funct3_legal(req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_funct3[1:0] == 2'd1 && req_addr[0]) req_err = 1'b1;
    if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
  end

  lsu_load_extend u_extend (
    .rd   (bus.read_data),
    .f3   (f3_q),
    .data (load_data)
  );

  // Bus address/data registers only move on a real dispatch so they hold otherwise
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= IDLE;
      addr_q           <= '0;
      wdata_q          <= '0;
      f3_q             <= '0;
      store_q          <= 1'b0;
      tmo_cnt          <= '0;
      dispatch_read_q  <= 1'b0;
      dispatch_write_q <= 1'b0;
      width_q          <= BYTE;
      resp_valid       <= 1'b0;
      resp_data        <= '0;
      resp_error       <= 1'b0;
    end else begin
      dispatch_read_q  <= 1'b0;
      dispatch_write_q <= 1'b0;
      resp_valid       <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            f3_q    <= req_funct3;
            store_q <= req_is_store;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_data  <= '0;
            end else begin
              state            <= DISPATCH;
              addr_q           <= req_addr;
              wdata_q          <= req_wdata;
              width_q          <= funct3_to_width(req_funct3);
              dispatch_read_q  <= !req_is_store;
              dispatch_write_q <= req_is_store;
            end
          end
        end
        DISPATCH: begin
          tmo_cnt <= TIMEOUT_LOAD;
          state   <= WAIT;
        end
        WAIT: begin
          if (!bus.busy) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_data  <= store_q ? '0 : load_data;
          end else if (tmo_cnt == 8'd1) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            resp_data  <= '0;
          end else begin
            tmo_cnt <= tmo_cnt - 8'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
